// File: rtl/alu_srl_pkg.sv
// Shared constants for the logical-shift-right unit: datapath width and
// the position of the shift-amount field inside rs2.
package alu_srl_pkg;
   localparam int XLEN     = 32;
   localparam int SHAMT_W  = 5;
   localparam int SHAMT_HI = SHAMT_W - 1;
   localparam int SHAMT_LO = 0;

   typedef logic [SHAMT_W-1:0] shamt_t;
endpackage

// File: rtl/alu_srl_stage.sv
// One level of the logarithmic barrel shifter: shifts right by DIST with
// zero fill when enable is set, otherwise passes data through.
module alu_srl_stage
   import alu_srl_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   output logic [WIDTH-1:0] shifted
);

   assign shifted = enable ? (data >> DIST) : data;

endmodule

// File: rtl/alu_srl.sv
// Single-cycle logical shift right: rd = rs1 >> rs2[4:0], built from five
// barrel levels feeding a registered result and valid flag.
module alu_srl
   import alu_srl_pkg::*;
#(
   parameter int XLEN = alu_srl_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   output logic [XLEN-1:0] rd
);

   shamt_t          shamt;
   logic            rs2_unused;
   logic [XLEN-1:0] level [0:SHAMT_W];
   logic [XLEN-1:0] rd_reg;
   logic [XLEN-1:0] rd_next;
   logic            out_valid_reg;

   assign shamt      = rs2[SHAMT_HI:SHAMT_LO];
   // Upper rs2 bits carry no meaning for a 32-bit shift.
   assign rs2_unused = ^rs2[XLEN-1:SHAMT_W];
   assign level[0]   = rs1;

   generate
      for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_level
         alu_srl_stage #(
            .WIDTH (XLEN),
            .DIST  (1 << gi)
         ) u_stage (
            .data    (level[gi]),
            .enable  (shamt[gi]),
            .shifted (level[gi+1])
         );
      end
   endgenerate

   assign rd_next = level[SHAMT_W];

   // rd holds its last value across idle cycles; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_reg        <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            rd_reg <= rd_next;
         end
      end
   end

   assign rd        = rd_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_srl.sv
// Directed and swept checks for alu_srl: latency, zero fill, idle hold,
// back-to-back issue and asynchronous reset mid-stream.
module tb_alu_srl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        out_valid;
   logic [31:0] rd;

   int n_cmp = 0;
   int n_err = 0;

   alu_srl #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .rd        (rd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one valid op at a falling edge, then check it one falling edge later.
   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
      rs1      = a;
      rs2      = b;
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, ".rd"}, rd, exp);
      check({tag, ".vld"}, {31'b0, out_valid}, 32'd1);
      $display("op %-10s rs1=%h rs2=%h rd=%h vld=%b", tag, a, b, rd, out_valid);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;

      @(negedge clk);
      check("rst.rd", rd, 32'h0);
      check("rst.vld", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle.vld", {31'b0, out_valid}, 32'd0);

      op("basic",    32'h0000_0002, 32'h0000_0001, 32'h0000_0001);
      op("lsb_out",  32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
      op("zfill",    32'h8000_0000, 32'h0000_0001, 32'h4000_0000);
      op("shamt4",   32'hDEAD_BEEF, 32'hFFFF_FFE4, 32'h0DEA_DBEE);
      op("shamt0",   32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF);
      op("shamt31",  32'hDEAD_BEEF, 32'h0000_001F, 32'h0000_0001);
      op("hi_ign",   32'hF000_000F, 32'hFFFF_FFE0, 32'hF000_000F);
      op("shamt16",  32'h1234_5678, 32'h0000_0010, 32'h0000_1234);
      op("shamt31b", 32'h7FFF_FFFF, 32'hAAAA_AABF, 32'h0000_0000);

      // Three back-to-back ops, then idle: rd must hold the last result.
      op("b2b0",     32'hFFFF_FFFF, 32'h0000_0008, 32'h00FF_FFFF);
      op("b2b1",     32'hA5A5_A5A5, 32'h0000_0003, 32'h14B4_B4B4);
      op("b2b2",     32'h8765_4321, 32'h0000_000C, 32'h0008_7654);
      in_valid = 1'b0;
      rs1      = 32'hFFFF_FFFF;
      rs2      = 32'h0;
      @(negedge clk);
      check("hold.vld", {31'b0, out_valid}, 32'd0);
      check("hold.rd", rd, 32'h0008_7654);
      @(negedge clk);
      check("hold2.rd", rd, 32'h0008_7654);
      $display("idle rd=%h vld=%b", rd, out_valid);

      // Reset mid-cycle with a valid op pending: clears at once, no clock needed.
      op("pre_rst",  32'hCAFE_F00D, 32'h0000_0004, 32'h0CAF_EF00);
      rs1 = 32'h1111_1111;
      rs2 = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check("arst.rd", rd, 32'h0);
      check("arst.vld", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("arst_hold.rd", rd, 32'h0);
      check("arst_hold.vld", {31'b0, out_valid}, 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      $display("reset released rd=%h vld=%b", rd, out_valid);
      op("post_rst", 32'h0000_0002, 32'h0000_0001, 32'h0000_0001);

      // Sweep every shift amount with random upper rs2 bits.
      for (int i = 0; i < 2048; i++) begin
         a = $urandom;
         b = ($urandom & 32'hFFFF_FFE0) | (i % 32);
         rs1      = a;
         rs2      = b;
         in_valid = 1'b1;
         @(negedge clk);
         check("sweep.rd", rd, a >> (i % 32));
         check("sweep.vld", {31'b0, out_valid}, 32'd1);
      end
      $display("sweep done, 2048 ops");

      in_valid = 1'b0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
